// File: rtl/jtvigil_pkg.sv
// jtvigil_pkg: shared definitions for the sound command transmitter.
// Holds the handshake FSM encoding and the default ack timeout.
package jtvigil_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_GAP  = 2'd2
   } sndcmd_state_t;

   localparam logic [15:0] DEF_TOUT = 16'd4096;

endpackage

// File: rtl/jtvigil_sndcmd_fifo.sv
// jtvigil_sndcmd_fifo: small circular byte buffer for queued sound commands.
// Depth is 2**AW. A pop and a push in the same cycle are both honoured,
// even when the buffer is full. Pushes into a full buffer are ignored here.
module jtvigil_sndcmd_fifo #(
   parameter int AW = 2
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic [7:0]    i_din,
   input  logic          i_pop,
   output logic [7:0]    o_head,
   output logic [AW:0]   o_level,
   output logic          o_full,
   output logic          o_empty
);

   localparam int DEPTH = 2**AW;
   localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_rdPtr;
   logic [AW-1:0] r_wrPtr;
   logic [AW:0]   r_level;
   logic          w_doPush;
   logic          w_doPop;

   assign o_full   = (r_level == FULL_LVL);
   assign o_empty  = (r_level == '0);
   assign w_doPop  = i_pop & ~o_empty;
   assign w_doPush = i_push & (~o_full | w_doPop);
   assign o_head   = r_mem[r_rdPtr];
   assign o_level  = r_level;

   // Storage array; contents need no reset since level gates every read
   always_ff @(posedge clk) begin
      if (w_doPush) r_mem[r_wrPtr] <= i_din;
   end

   // Pointers wrap naturally at 2**AW; level tracks the push/pop balance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_level <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
         case ({w_doPush, w_doPop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/jtvigil_sndcmd.sv
// jtvigil_sndcmd: main-CPU side transmitter for the sound command latch.
// Queues main CPU writes and forwards them one at a time, waiting for the
// sound CPU to clear its latch interrupt before sending the next byte.
// Optional ack timeout: define JTVIGIL_SNDCMD_TIMEOUT_EN (adds TOUT parameter).
module jtvigil_sndcmd
   import jtvigil_pkg::*;
#(
   parameter int AW = 2
`ifdef JTVIGIL_SNDCMD_TIMEOUT_EN
   ,
   parameter logic [15:0] TOUT = DEF_TOUT
`endif
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          main_wr,
   input  logic [7:0]    main_dout,
   input  logic          snd_ack,
   input  logic          ovf_clr,
   output logic          latch_wr,
   output logic [7:0]    latch_dout,
   output logic          busy,
   output logic [AW:0]   level,
   output logic          ovf
);

   sndcmd_state_t r_state;
   sndcmd_state_t w_nextState;

   logic       r_mainWrL;
   logic       w_push;
   logic       w_pop;
   logic       w_drop;
   logic       w_timeout;
   logic [7:0] w_head;
   logic       w_full;
   logic       w_empty;
   logic       r_latchWr;
   logic [7:0] r_latchDout;
   logic       r_ovf;

   // One push per rising edge of the CPU strobe; a full buffer with no
   // simultaneous pop means the byte is lost
   assign w_push = main_wr & ~r_mainWrL;
   assign w_drop = w_push & w_full & ~w_pop;

   // Previous strobe level, used to turn a long CPU write into one push
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_mainWrL <= 1'b0;
      else        r_mainWrL <= main_wr;
   end

   jtvigil_sndcmd_fifo #(
      .AW(AW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_din   (main_dout),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_level (level),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

`ifdef JTVIGIL_SNDCMD_TIMEOUT_EN
   logic [15:0] r_toutCnt;

   // Cycles spent waiting for the current ack; restarts with every new byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  r_toutCnt <= '0;
      else if (w_pop)              r_toutCnt <= '0;
      else if (r_state == ST_WAIT) r_toutCnt <= r_toutCnt + 16'd1;
   end

   assign w_timeout = (r_state == ST_WAIT) && (r_toutCnt == TOUT - 16'd1);
`else
   assign w_timeout = 1'b0;
`endif

   // Handshake sequencing: send from IDLE, hold in WAIT until acked, then
   // spend one GAP cycle so consecutive pulses are well separated
   always_comb begin
      w_nextState = r_state;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_nextState = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (snd_ack || w_timeout) w_nextState = ST_GAP;
         end
         ST_GAP: begin
            w_nextState = ST_IDLE;
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_nextState;
   end

   // Latch strobe pulses for the cycle after a pop; the data stays put after it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_latchWr   <= 1'b0;
         r_latchDout <= 8'h00;
      end else begin
         r_latchWr <= w_pop;
         if (w_pop) r_latchDout <= w_head;
      end
   end

   // Sticky overflow flag; a drop in the same cycle as a clear leaves it set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_ovf <= 1'b0;
      else if (w_drop)  r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
   end

   assign latch_wr   = r_latchWr;
   assign latch_dout = r_latchDout;
   assign busy       = (r_state == ST_WAIT);
   assign ovf        = r_ovf;

endmodule

// File: tb/tb_jtvigil_sndcmd.sv
// tb_jtvigil_sndcmd: self-checking bench for the sound command transmitter.
// A queue-based model predicts every output each cycle; directed scenarios
// add hand-computed literal checks. Define JTVIGIL_SNDCMD_TIMEOUT_EN to
// exercise the ack timeout build.
module tb_jtvigil_sndcmd;

   localparam int AW      = 2;
   localparam int DEPTH   = 4;
   localparam int TOUT_TB = 16;
`ifdef JTVIGIL_SNDCMD_TIMEOUT_EN
   localparam bit TOUT_EN = 1'b1;
`else
   localparam bit TOUT_EN = 1'b0;
`endif

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b1;
   logic          main_wr   = 1'b0;
   logic [7:0]    main_dout = 8'h00;
   logic          snd_ack   = 1'b0;
   logic          ovf_clr   = 1'b0;
   logic          latch_wr;
   logic [7:0]    latch_dout;
   logic          busy;
   logic [AW:0]   level;
   logic          ovf;

   int nChecks = 0;
   int nFails  = 0;
   int cyc     = 0;

   logic [7:0] seen[$];
   int         seenCyc[$];

   // Model state: pending bytes, whether a byte awaits its ack, and the
   // number of quiet cycles still owed before the next send
   logic [7:0] mQ[$];
   logic       mPrevWr     = 1'b0;
   logic       mAwaitAck   = 1'b0;
   int         mCoolDown   = 0;
   int         mWaitCycles = 0;
   logic       mWr         = 1'b0;
   logic [7:0] mDout       = 8'h00;
   logic       mOvf        = 1'b0;
   logic       mPush;
   logic       mFull;
   logic       mSend;
   logic       mDrop;

   jtvigil_sndcmd #(
      .AW(AW)
`ifdef JTVIGIL_SNDCMD_TIMEOUT_EN
      ,
      .TOUT(16'(TOUT_TB))
`endif
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .main_wr    (main_wr),
      .main_dout  (main_dout),
      .snd_ack    (snd_ack),
      .ovf_clr    (ovf_clr),
      .latch_wr   (latch_wr),
      .latch_dout (latch_dout),
      .busy       (busy),
      .level      (level),
      .ovf        (ovf)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks = nChecks + 1;
      if (act !== exp) begin
         nFails = nFails + 1;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input logic wr, input logic [7:0] dout, input logic ack, input logic clr);
      main_wr   = wr;
      main_dout = dout;
      snd_ack   = ack;
      ovf_clr   = clr;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic writeByte(input logic [7:0] b);
      applyStimulus(1'b1, b, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, b, 1'b0, 1'b0);
      @(negedge clk);
   endtask

   task automatic pulseAck();
      applyStimulus(1'b0, main_dout, 1'b1, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, main_dout, 1'b0, 1'b0);
   endtask

   task automatic waitSent(input int n, input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         if (seen.size() >= n) break;
         @(negedge clk);
      end
      checkOutput(name, 32'(seen.size() >= n), 32'd1);
   endtask

   // Cycle counter for timing measurements
   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   // Behavioural model advanced on each clock edge, reset asynchronously
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mQ.delete();
            mPrevWr     = 1'b0;
            mAwaitAck   = 1'b0;
            mCoolDown   = 0;
            mWaitCycles = 0;
            mWr         = 1'b0;
            mDout       = 8'h00;
            mOvf        = 1'b0;
         end else begin
            mPush   = main_wr && !mPrevWr;
            mPrevWr = main_wr;
            mFull   = (mQ.size() == DEPTH);
            mSend   = !mAwaitAck && (mCoolDown == 0) && (mQ.size() != 0);
            mWr     = mSend;
            if (mSend) begin
               mDout       = mQ.pop_front();
               mAwaitAck   = 1'b1;
               mWaitCycles = 1;
            end else if (mAwaitAck) begin
               if (snd_ack || (TOUT_EN && mWaitCycles == TOUT_TB)) begin
                  mAwaitAck = 1'b0;
                  mCoolDown = 1;
               end else begin
                  mWaitCycles = mWaitCycles + 1;
               end
            end else if (mCoolDown > 0) begin
               mCoolDown = mCoolDown - 1;
            end
            mDrop = mPush && mFull && !mSend;
            if (mPush && !mDrop) mQ.push_back(main_dout);
            if (mDrop)        mOvf = 1'b1;
            else if (ovf_clr) mOvf = 1'b0;
         end
      end
   end

   // Record every byte the DUT sends, shortly after the edge that sends it
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && latch_wr) begin
            seen.push_back(latch_dout);
            seenCyc.push_back(cyc);
         end
      end
   end

   // Compare every DUT output against the model each cycle
   initial begin
      forever begin
         @(negedge clk);
         checkOutput("latch_wr",   32'(latch_wr),   32'(mWr));
         checkOutput("latch_dout", 32'(latch_dout), 32'(mDout));
         checkOutput("busy",       32'(busy),       32'(mAwaitAck));
         checkOutput("level",      32'(level),      32'(mQ.size()));
         checkOutput("ovf",        32'(ovf),        32'(mOvf));
      end
   end

   // Watchdog so a stuck run still ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios
   initial begin
      logic [7:0] expT2 [3];
      logic [7:0] expT3 [6];
      int base;
      expT2 = '{8'h01, 8'h02, 8'h03};
      expT3 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA7};

      // Reset values
      #1 rst_n = 1'b0;
      #2;
      checkOutput("rst_latch_wr",   32'(latch_wr),   32'd0);
      checkOutput("rst_latch_dout", 32'(latch_dout), 32'd0);
      checkOutput("rst_busy",       32'(busy),       32'd0);
      checkOutput("rst_level",      32'(level),      32'd0);
      checkOutput("rst_ovf",        32'(ovf),        32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      // Long strobe: one push, pulse two edges after the strobe appears
      applyStimulus(1'b1, 8'h3A, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t1_level_after_push", 32'(level),    32'd1);
      checkOutput("t1_no_pulse_yet",     32'(latch_wr), 32'd0);
      @(negedge clk);
      checkOutput("t1_pulse",        32'(latch_wr),   32'd1);
      checkOutput("t1_dout",         32'(latch_dout), 32'h3A);
      checkOutput("t1_level_empty",  32'(level),      32'd0);
      checkOutput("t1_busy",         32'(busy),       32'd1);
      @(negedge clk);
      checkOutput("t1_pulse_single", 32'(latch_wr),   32'd0);
      @(negedge clk);
      applyStimulus(1'b0, 8'h3A, 1'b0, 1'b0);
      tick(10);
      checkOutput("t1_one_byte",     32'(seen.size()), 32'd1);
      checkOutput("t1_still_busy",   32'(busy),        32'd1);
      pulseAck();
      tick(3);
      checkOutput("t1_busy_cleared", 32'(busy),        32'd0);

      // Back-to-back writes, each acked 20 cycles after its pulse
      base = seen.size();
      writeByte(8'h01);
      writeByte(8'h02);
      writeByte(8'h03);
      for (int i = 0; i < 3; i++) begin
         waitSent(base + i + 1, 100, "t2_sent");
         tick(20);
         pulseAck();
      end
      tick(4);
      checkOutput("t2_count", 32'(seen.size()), 32'(base + 3));
      for (int i = 0; i < 3; i++) begin
         if (seen.size() > base + i)
            checkOutput("t2_order", 32'(seen[base + i]), 32'(expT2[i]));
      end

      // Fill to capacity, overflow, clear, drop-beats-clear, push+pop at full
      base = seen.size();
      writeByte(8'hA0);
      writeByte(8'hA1);
      writeByte(8'hA2);
      writeByte(8'hA3);
      writeByte(8'hA4);
      checkOutput("t3_level_full", 32'(level), 32'd4);
      checkOutput("t3_no_ovf_yet", 32'(ovf),   32'd0);
      writeByte(8'hA5);
      checkOutput("t3_ovf_set",    32'(ovf),   32'd1);
      checkOutput("t3_level_kept", 32'(level), 32'd4);
      applyStimulus(1'b0, 8'hA5, 1'b0, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 8'hA5, 1'b0, 1'b0);
      checkOutput("t3_ovf_cleared", 32'(ovf), 32'd0);
      applyStimulus(1'b1, 8'hA6, 1'b0, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 8'hA6, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t3_drop_beats_clr", 32'(ovf), 32'd1);
      applyStimulus(1'b0, 8'hA6, 1'b0, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 8'hA6, 1'b0, 1'b0);
      pulseAck();
      @(negedge clk);
      applyStimulus(1'b1, 8'hA7, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 8'hA7, 1'b0, 1'b0);
      checkOutput("t3_full_pushpop_level", 32'(level), 32'd4);
      checkOutput("t3_full_pushpop_ovf",   32'(ovf),   32'd0);
      for (int i = 1; i < 6; i++) begin
         waitSent(base + i + 1, 60, "t3_sent");
         tick(2);
         pulseAck();
      end
      tick(10);
      checkOutput("t3_count", 32'(seen.size()), 32'(base + 6));
      for (int i = 0; i < 6; i++) begin
         if (seen.size() > base + i)
            checkOutput("t3_order", 32'(seen[base + i]), 32'(expT3[i]));
      end

      // Stray ack while idle is ignored
      base = seen.size();
      pulseAck();
      tick(3);
      writeByte(8'h55);
      waitSent(base + 1, 20, "t4_sent");
      tick(5);
      checkOutput("t4_busy_held", 32'(busy),       32'd1);
      checkOutput("t4_dout",      32'(latch_dout), 32'h55);

      // Asynchronous reset while waiting with two bytes queued
      writeByte(8'h66);
      writeByte(8'h77);
      tick(2);
      checkOutput("t5_level_pre", 32'(level), 32'd2);
      checkOutput("t5_busy_pre",  32'(busy),  32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t5_latch_wr",   32'(latch_wr),   32'd0);
      checkOutput("t5_latch_dout", 32'(latch_dout), 32'd0);
      checkOutput("t5_busy",       32'(busy),       32'd0);
      checkOutput("t5_level",      32'(level),      32'd0);
      checkOutput("t5_ovf",        32'(ovf),        32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      base = seen.size();
      tick(10);
      checkOutput("t5_nothing_sent", 32'(seen.size()), 32'(base));
      checkOutput("t5_idle",         32'(busy),        32'd0);

      // Unacked byte: timeout build moves on, default build holds forever
      base = seen.size();
      writeByte(8'h88);
      writeByte(8'h99);
      waitSent(base + 1, 20, "t6_first_sent");
`ifdef JTVIGIL_SNDCMD_TIMEOUT_EN
      waitSent(base + 2, 60, "t6_second_after_timeout");
      if (seenCyc.size() >= base + 2)
         checkOutput("t6_pulse_spacing", 32'(seenCyc[base + 1] - seenCyc[base]), 32'd18);
      if (seen.size() >= base + 2)
         checkOutput("t6_second_byte", 32'(seen[base + 1]), 32'h99);
      tick(40);
      checkOutput("t6_idle_after", 32'(busy), 32'd0);
`else
      tick(10000);
      checkOutput("t6_busy_held",  32'(busy),        32'd1);
      checkOutput("t6_level_held", 32'(level),       32'd1);
      checkOutput("t6_one_sent",   32'(seen.size()), 32'(base + 1));
      pulseAck();
      waitSent(base + 2, 20, "t6_second_sent");
      tick(2);
      pulseAck();
      tick(5);
      checkOutput("t6_idle_after", 32'(busy), 32'd0);
`endif

      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/jtvigil_sndcmd.md
Name: jtvigil_sndcmd

Overview:
- Main-CPU-side transmitter for the sound command latch.
- Buffers main CPU sound-command writes in a small FIFO.
- Forwards one byte at a time to the sound board's latch input, as a `latch_wr` pulse plus data.
- Holds the next byte until the sound CPU acknowledges the previous one (sound-side IRQ clear), so back-to-back commands are not overwritten.

Parameters:
- AW, 2, FIFO address width; depth = 2**AW entries.
- TOUT, 16'd4096, clk cycles to wait for an ack before giving up; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset.
- main_wr  input  1  main CPU write strobe to the sound-command address; level signal, may stay high several cycles.
- main_dout  input  8  main CPU data bus.
- snd_ack  input  1  one-cycle pulse from the sound side when it clears its latch interrupt.
- ovf_clr  input  1  clears the sticky overflow flag.
- latch_wr  output  1  one-cycle pulse to the sound latch.
- latch_dout  output  8  byte presented with `latch_wr`; held stable afterwards.
- busy  output  1  high while a byte is waiting for an ack.
- level  output  AW+1  FIFO occupancy, 0..2**AW.
- ovf  output  1  sticky flag: a write was dropped because the FIFO was full.

Interface rule: one clock; reset is asynchronous and active-low. The clock port is `clk` and the reset port is `rst_n`.

Behaviour:
- Reset (asserted asynchronously, any state): FIFO pointers and level = 0, `latch_wr` = 0, `latch_dout` = 8'h00, `busy` = 0, `ovf` = 0, FSM = IDLE, timeout counter = 0.
- Write capture:
  - `main_wr_l` registers `main_wr`.
  - push = `main_wr & ~main_wr_l`, i.e. exactly one push per rising edge, capturing `main_dout` in that cycle.
  - Push with level == 2**AW: byte dropped, `ovf` <= 1 on the next edge.
- `ovf_clr` clears `ovf`. A drop in the same cycle as `ovf_clr` wins: `ovf` ends at 1.
- FIFO: circular buffer, pointers wrap modulo 2**AW.
  - `level` updates +1 (push), −1 (pop), unchanged (push and pop in the same cycle).
  - A push and a pop in the same cycle are both legal, including at full; this adds no ovf.
- FSM states:
  - IDLE: if level != 0, pop the head. On the next edge, `latch_dout` <= head and `latch_wr` <= 1 for exactly one cycle. Go to WAIT.
  - WAIT: `busy` = 1. On `snd_ack`, go to GAP.
    - `snd_ack` during IDLE or GAP is ignored.
    - `snd_ack` in the same cycle `latch_wr` is high is counted (WAIT is entered with that edge).
  - GAP: one cycle, `busy` = 0, then IDLE. Guarantees at least 2 idle cycles between consecutive `latch_wr` pulses.
- Latency: rising edge of `main_wr` sampled at edge N with FIFO empty and FSM IDLE → `level` = 1 after edge N+1 → `latch_wr` high after edge N+2, with `latch_dout` = the byte.
- Ordering: strict FIFO order. No byte is sent twice.

Optional Feature:
- Macro: JTVIGIL_SNDCMD_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TOUT−1 without an ack, the FSM goes to GAP as if acked.
  - The byte is considered delivered, not resent.
- Undefined: counter absent; WAIT exits only on `snd_ack`.

Decomposition:
- Shared package `jtvigil_pkg`: FSM state encoding (IDLE=2'd0, WAIT=2'd1, GAP=2'd2) and default TOUT constant.
- One sub-module is natural: `jtvigil_sndcmd_fifo` (AW-parameterised circular buffer with push/pop/level/full/empty).
- The top holds the edge detect, FSM, ovf flag and timeout.

Test Plan:
- Reset, then `main_wr` high 4 cycles with `main_dout`=8'h3A → exactly one `latch_wr` pulse, 2 cycles after the sampled edge, `latch_dout`=8'h3A, `level` back to 0, `busy`=1 until `snd_ack`.
- Write 8'h01, 8'h02, 8'h03 back-to-back, ack each 20 cycles after its `latch_wr` → three pulses, order 01, 02, 03, each at least 2 cycles after the preceding ack edge.
- AW=2: five writes with no acks → first byte sent; `level` reaches 4 after the fifth write; a sixth write sets `ovf`=1 and that byte is never sent; pulsing `ovf_clr` clears it.
- `snd_ack` pulsed while IDLE with an empty FIFO, then a write of 8'h55 → 8'h55 is sent and the FSM stays in WAIT (stray ack ignored).
- Deassert `rst_n` in WAIT with `level`=2 → all outputs at reset values immediately. After release, `latch_wr` stays 0 until a new write.
- Macro defined, TOUT=16, no ack → FSM leaves WAIT after 16 cycles and the next queued byte pulses 2 cycles later. Macro undefined → WAIT holds for 10000 cycles.
